fetch_unit: RTL

Instruction fetch / PC sequencer for the rv32i core. It is the consumer of the branch controller's redirect outputs (jmp_enable, jmp_addr). It owns the program counter, issues word fetches to instruction memory over a req/gnt + rvalid handshake, and presents each fetched instruction to decode with a valid/ready handshake. Redirects squash in-flight or held fetches; misaligned targets halt fetch with a sticky trap flag.

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit handshake bundle: redirect, imem req/gnt/rvalid, decode valid/ready
interface fetch_unit_if;
  logic        jmp_enable;
  logic [31:0] jmp_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        trap_misaligned;

  modport master (
    input  jmp_enable, jmp_addr, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, trap_misaligned
  );

  modport slave (
    output jmp_enable, jmp_addr, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, trap_misaligned
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - rv32i PC sequencer: one outstanding word fetch, decode handoff, redirect and misaligned trap
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic        redirect;
  logic        misaligned;
  logic        outstanding;

  assign bus.imem_addr = pc;
  assign redirect      = bus.jmp_enable && (state == REQ || state == WAIT || state == HOLD);
  assign misaligned    = bus.jmp_addr[1:0] != 2'b00;
  // A fetch is in flight if it was granted this cycle or is still waiting for its rvalid.
  assign outstanding   = (state == REQ && bus.imem_gnt) || (state == WAIT && !bus.imem_rvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      pc                  <= RESET_PC;
      drop                <= 1'b0;
      bus.imem_req        <= 1'b0;
      bus.inst_valid      <= 1'b0;
      bus.inst            <= 32'h0;
      bus.inst_pc         <= 32'h0;
      bus.trap_misaligned <= 1'b0;
    end else if (redirect && misaligned) begin
      bus.trap_misaligned <= 1'b1;
      bus.inst_valid      <= 1'b0;
      bus.imem_req        <= 1'b0;
      drop                <= outstanding;
      state               <= HALT;
    end else begin
      case (state)
        IDLE: begin
          bus.imem_req <= 1'b1;
          state        <= REQ;
        end
        REQ: begin
          if (redirect) pc <= bus.jmp_addr;
          if (bus.imem_gnt) begin
            bus.imem_req <= 1'b0;
            drop         <= redirect;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc <= bus.jmp_addr;
            if (bus.imem_rvalid) begin
              drop         <= 1'b0;
              bus.imem_req <= 1'b1;
              state        <= REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (bus.imem_rvalid) begin
            if (drop) begin
              drop         <= 1'b0;
              bus.imem_req <= 1'b1;
              state        <= REQ;
            end else begin
              bus.inst       <= bus.imem_rdata;
              bus.inst_pc    <= pc;
              bus.inst_valid <= 1'b1;
              state          <= HOLD;
            end
          end
        end
        HOLD: begin
          // The redirect wins over inst_ready: the consumed instruction caused it, so no pc+4.
          if (redirect) begin
            pc             <= bus.jmp_addr;
            bus.inst_valid <= 1'b0;
            bus.imem_req   <= 1'b1;
            state          <= REQ;
          end else if (bus.inst_ready) begin
            pc             <= pc + 32'd4;
            bus.inst_valid <= 1'b0;
            bus.imem_req   <= 1'b1;
            state          <= REQ;
          end
        end
        HALT: begin
          bus.imem_req   <= 1'b0;
          bus.inst_valid <= 1'b0;
        end
        default: begin
          bus.imem_req <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
